prog_exec_unit: RTL and testbench



---
 rtl/prog_exec_pkg.sv | 45 ++++
 rtl/prog_exec_unit_out_fifo.sv | 51 +++++
 rtl/prog_exec_unit.sv | 184 ++++++++++++++++++
 tb/tb_prog_exec_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_exec_pkg.sv
// Shared definitions for the program-execution unit: opcodes, status/state
// encodings and instruction field extraction for a {op, a, b, imm} word.
package prog_exec_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JEQ  = 4'd2;
  localparam logic [3:0] OP_JNE  = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_OUT  = 4'd6;
  localparam logic [3:0] OP_OUTI = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_TIMEOUT = 2'd1,
    STAT_ILLEGAL = 2'd2,
    STAT_RSVD    = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Fields come back zero-extended to 32 bits; callers slice to LA/W.
  function automatic logic [31:0] instr_op(input logic [31:0] instr, input int la, input int w);
    return (instr >> (2 * la + w)) & 32'hF;
  endfunction

  function automatic logic [31:0] instr_a(input logic [31:0] instr, input int la, input int w);
    return (instr >> (la + w)) & ((32'd1 << la) - 32'd1);
  endfunction

  function automatic logic [31:0] instr_b(input logic [31:0] instr, input int la, input int w);
    return (instr >> w) & ((32'd1 << la) - 32'd1);
  endfunction

  function automatic logic [31:0] instr_imm(input logic [31:0] instr, input int w);
    return instr & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/prog_exec_unit_out_fifo.sv
// Output FIFO for the execution unit: pointer-based ring with an occupancy
// counter; head is read combinationally so it can drive the output channel.
module out_fifo #(
  parameter int W    = 12,
  parameter int NOut = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int AW = $clog2(NOut);
  localparam int CW = $clog2(NOut + 1);

  logic [W-1:0]  mem_q [NOut];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(NOut));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/prog_exec_unit.sv
// Run-time programmable test harness: executes one instruction per cycle from
// a loadable store and streams results through a buffered valid/ready channel.
module prog_exec_unit
  import prog_exec_pkg::*;
#(
  parameter int W        = 12,
  parameter int NLocal   = 16,
  parameter int NProg    = 64,
  parameter int NOut     = 8,
  parameter int MaxSteps = 1024,
  localparam int LA = $clog2(NLocal),
  localparam int PA = $clog2(NProg),
  localparam int SW = $clog2(MaxSteps + 1),
  localparam int IW = 4 + 2 * LA + W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [PA-1:0] load_addr,
  input  logic [IW-1:0] load_instr,
  input  logic          run,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic          success,
  output logic [1:0]    status,
  output logic [SW-1:0] steps
);
  state_e         state_q, state_d;
  status_e        status_q, status_d;
  logic [PA-1:0]  ip_q, ip_d;
  logic [SW-1:0]  steps_q, steps_d;
  logic [W-1:0]   locals_q [NLocal];
  logic [IW-1:0]  store [NProg];

  logic [31:0]    instr_w, op_w, a_w, b_w, imm_w;
  logic [3:0]     op;
  logic [LA-1:0]  a_idx, b_idx;
  logic [W-1:0]   imm, la, lb;
  logic           start, loc_we, push, fifo_full, fifo_empty, take, advance;
  logic [W-1:0]   loc_wdata, push_data;
  logic           unused_fields;

  assign instr_w = 32'(store[ip_q]);
  assign op_w    = instr_op(instr_w, LA, W);
  assign a_w     = instr_a(instr_w, LA, W);
  assign b_w     = instr_b(instr_w, LA, W);
  assign imm_w   = instr_imm(instr_w, W);
  assign op      = op_w[3:0];
  assign a_idx   = a_w[LA-1:0];
  assign b_idx   = b_w[LA-1:0];
  assign imm     = imm_w[W-1:0];
  assign la      = locals_q[a_idx];
  assign lb      = locals_q[b_idx];
  assign unused_fields = ^{op_w[31:4], a_w[31:LA], b_w[31:LA], imm_w[31:W]};

  assign start = run && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clock) begin
    if (load_valid && state_q == S_IDLE) store[load_addr] <= load_instr;
  end

  // Locals survive reset; only a run start clears them.
  always_ff @(posedge clock) begin
    if (start) begin
      for (int i = 0; i < NLocal; i++) locals_q[i] <= '0;
    end else if (loc_we) begin
      locals_q[a_idx] <= loc_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      status_q <= STAT_OK;
      ip_q     <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      ip_q     <= ip_d;
      steps_q  <= steps_d;
    end
  end

  // HALT and an out-of-range JMP end the run without counting as a step;
  // an illegal opcode does count.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    ip_d      = ip_q;
    steps_d   = steps_q;
    loc_we    = 1'b0;
    loc_wdata = imm;
    push      = 1'b0;
    push_data = imm;
    take      = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          state_d  = S_RUN;
          status_d = STAT_OK;
          ip_d     = '0;
          steps_d  = '0;
        end
      end
      S_RUN: begin
        if (steps_q == SW'(MaxSteps)) begin
          state_d  = S_DONE;
          status_d = STAT_TIMEOUT;
        end else begin
          steps_d = steps_q + SW'(1);
          case (op)
            OP_NOP: advance = 1'b1;
            OP_JMP: take = 1'b1;
            OP_JEQ: if (la == lb) take = 1'b1; else advance = 1'b1;
            OP_JNE: if (la != lb) take = 1'b1; else advance = 1'b1;
            OP_MOV: begin
              loc_we  = 1'b1;
              advance = 1'b1;
            end
            OP_ADD: begin
              loc_we    = 1'b1;
              loc_wdata = la + lb;
              advance   = 1'b1;
            end
            OP_OUT, OP_OUTI: begin
              if (fifo_full) begin
                steps_d = steps_q;
              end else begin
                push      = 1'b1;
                push_data = (op == OP_OUT) ? la : imm;
                advance   = 1'b1;
              end
            end
            OP_HALT: begin
              steps_d = steps_q;
              state_d = S_DONE;
            end
            default: begin
              state_d  = S_DONE;
              status_d = STAT_ILLEGAL;
            end
          endcase
          if (take) begin
            if (imm_w < 32'(NProg)) begin
              ip_d = imm_w[PA-1:0];
            end else begin
              steps_d = steps_q;
              state_d = S_DONE;
            end
          end
          if (advance) begin
            if (ip_q == PA'(NProg - 1)) state_d = S_DONE;
            else ip_d = ip_q + PA'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  out_fifo #(.W(W), .NOut(NOut)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (out_ready),
    .head      (out_data),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state_q == S_RUN);
  assign finished  = (state_q == S_DONE);
  assign success   = finished && (status_q == STAT_OK);
  assign status    = status_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_prog_exec_unit.sv
// Scoreboard bench for prog_exec_unit: a 2-deep-FIFO instance for the main
// programs and a MaxSteps=16 instance for timeout and mid-run reset.
module tb_prog_exec_unit;
  localparam int W = 12, LA = 4, PA = 6, IW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [PA-1:0] load_addr = '0;
  logic [IW-1:0] load_instr = '0;
  logic          run = 1'b0, to_run = 1'b0;
  logic          out_ready = 1'b0, to_ready = 1'b0;

  logic          out_valid, busy, finished, success;
  logic [W-1:0]  out_data;
  logic [1:0]    status;
  logic [10:0]   steps;
  logic          to_out_valid, to_busy, to_finished, to_success;
  logic [W-1:0]  to_out_data;
  logic [1:0]    to_status;
  logic [4:0]    to_steps;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_to_q[$];
  logic [IW-1:0] prog_q[$];

  always #5 clock = ~clock;

  prog_exec_unit #(.NOut(2)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
    .load_instr(load_instr), .run(run), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .finished(finished), .success(success),
    .status(status), .steps(steps)
  );

  prog_exec_unit #(.MaxSteps(16)) dut_to (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
    .load_instr(load_instr), .run(to_run), .out_valid(to_out_valid), .out_data(to_out_data),
    .out_ready(to_ready), .busy(to_busy), .finished(to_finished), .success(to_success),
    .status(to_status), .steps(to_steps)
  );

  function automatic logic [IW-1:0] enc(input int op, input int a, input int b, input int imm);
    logic [3:0] o; logic [3:0] ra; logic [3:0] rb; logic [11:0] im;
    o = op[3:0]; ra = a[3:0]; rb = b[3:0]; im = imm[11:0];
    return {o, ra, rb, im};
  endfunction

  // Scoreboard monitors: one accepted beat per line.
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%0d expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data got=%0d expected=%0d", out_data, e);
        end else $display("dut out %0d", out_data);
      end
    end
    if (to_out_valid && to_ready) begin
      checks++;
      if (exp_to_q.size() == 0) begin
        errors++;
        $display("FAIL to_out_unexpected got=%0d expected=none", to_out_data);
      end else begin
        e = exp_to_q.pop_front();
        if (to_out_data !== e) begin
          errors++;
          $display("FAIL to_out_data got=%0d expected=%0d", to_out_data, e);
        end else $display("dut_to out %0d", to_out_data);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic load_prog();
    foreach (prog_q[i]) begin
      load_valid = 1'b1; load_addr = PA'(i); load_instr = prog_q[i]; step();
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !finished; i++) step();
    checks++;
    if (finished !== 1'b1) begin errors++; $display("FAIL dut_finish_timeout got=%b expected=1", finished); end
  endtask

  task automatic wait_to_done(input int budget);
    for (int i = 0; i < budget && !to_finished; i++) step();
    checks++;
    if (to_finished !== 1'b1) begin errors++; $display("FAIL to_finish_timeout got=%b expected=1", to_finished); end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_to_q.size() != 0); i++) step();
    checks++;
    if (exp_q.size() + exp_to_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size() + exp_to_q.size());
    end
  endtask

  task automatic check_result(input string name, input logic [1:0] st, input logic succ, input int n);
    checks++;
    if (status !== st || success !== succ || steps !== 11'(n)) begin
      errors++;
      $display("FAIL %s got status=%0d success=%b steps=%0d expected status=%0d success=%b steps=%0d",
               name, status, success, steps, st, succ, n);
    end else $display("%s status=%0d steps=%0d", name, status, steps);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, busy, finished, success, status, steps} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got ov=%b busy=%b fin=%b succ=%b st=%0d steps=%0d expected all 0",
               out_valid, busy, finished, success, status, steps);
    end else $display("reset state ok");
  endtask

  task automatic test_jmp_dead_code();
    do_reset();
    prog_q = {enc(1,0,0,3), enc(7,0,0,1), enc(7,0,0,9), enc(0,0,0,0),
              enc(7,0,0,2), enc(0,0,0,0), enc(8,0,0,0)};
    load_prog();
    out_ready = 1'b1;
    exp_q.push_back(12'd2);
    run = 1'b1; step(); run = 1'b0;
    wait_done(100);
    check_result("jmp_dead_code", 2'd0, 1'b1, 4);
    wait_drain();
  endtask

  task automatic test_count_loop();
    do_reset();
    prog_q = {enc(4,0,0,0), enc(4,1,0,1), enc(4,2,0,5), enc(5,0,1,0),
              enc(6,0,0,0), enc(3,0,2,3), enc(8,0,0,0)};
    load_prog();
    out_ready = 1'b1;
    for (int v = 1; v <= 5; v++) exp_q.push_back(W'(v));
    run = 1'b1; step(); run = 1'b0;
    wait_done(200);
    check_result("count_loop", 2'd0, 1'b1, 18);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    // Restart from DONE with no reset: locals cleared, same program reruns.
    for (int v = 1; v <= 5; v++) exp_q.push_back(W'(v));
    run = 1'b1; step(); run = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b expected=1", busy); end
    wait_done(200);
    check_result("restart", 2'd0, 1'b1, 18);
    wait_drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    prog_q = {enc(7,0,0,10), enc(7,0,0,11), enc(7,0,0,12), enc(7,0,0,13),
              enc(7,0,0,14), enc(8,0,0,0)};
    load_prog();
    out_ready = 1'b0;
    for (int v = 10; v <= 14; v++) exp_q.push_back(W'(v));
    run = 1'b1; step(); run = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (busy !== 1'b1 || steps !== 11'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall got busy=%b steps=%0d ov=%b expected busy=1 steps=2 ov=1", busy, steps, out_valid);
    end else $display("stall busy=%b steps=%0d", busy, steps);
    out_ready = 1'b1;
    wait_done(100);
    check_result("backpressure", 2'd0, 1'b1, 5);
    wait_drain();
  endtask

  task automatic test_timeout();
    do_reset();
    prog_q = {enc(1,0,0,0)};
    load_prog();
    to_ready = 1'b1;
    to_run = 1'b1; step(); to_run = 1'b0;
    wait_to_done(100);
    checks++;
    if (to_status !== 2'd1 || to_success !== 1'b0 || to_steps !== 5'd16) begin
      errors++;
      $display("FAIL timeout got status=%0d success=%b steps=%0d expected status=1 success=0 steps=16",
               to_status, to_success, to_steps);
    end else $display("timeout status=%0d steps=%0d", to_status, to_steps);
  endtask

  task automatic test_illegal();
    do_reset();
    prog_q = {enc(0,0,0,0), enc(0,0,0,0), enc(12,0,0,0)};
    load_prog();
    run = 1'b1; step(); run = 1'b0;
    wait_done(50);
    check_result("illegal", 2'd2, 1'b0, 3);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    prog_q = {enc(7,0,0,21), enc(7,0,0,22), enc(7,0,0,23), enc(1,0,0,3)};
    load_prog();
    to_ready = 1'b0;
    to_run = 1'b1; step(); to_run = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (to_out_valid !== 1'b1 || to_busy !== 1'b1) begin
      errors++;
      $display("FAIL queued got ov=%b busy=%b expected ov=1 busy=1", to_out_valid, to_busy);
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (to_out_valid !== 1'b0 || to_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got ov=%b busy=%b expected ov=0 busy=0", to_out_valid, to_busy);
    end else $display("mid-run reset dropped fifo");
    for (int v = 21; v <= 23; v++) exp_to_q.push_back(W'(v));
    to_ready = 1'b1;
    to_run = 1'b1; step(); to_run = 1'b0;
    wait_to_done(100);
    checks++;
    if (to_status !== 2'd1 || to_steps !== 5'd16) begin
      errors++;
      $display("FAIL rerun got status=%0d steps=%0d expected status=1 steps=16", to_status, to_steps);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_jmp_dead_code();
    test_count_loop();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_illegal();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
